case_sel_mux: RTL and testbench
===============================

Name: case_sel_mux

Overview:
Parametrised N-channel select multiplexer that implements priority-case and unique-case semantics in hardware, with a registered valid/ready output stage.
Each accepted beat presents a match vector, with one bit per case item, plus N data words. The block selects one word, flags full-case violations (no item matches) and parallel-case violations (more than one item matches), and keeps saturating violation counters.
It sits between a decoder that produces match vectors and a downstream consumer, and serves as the synthesizable, checkable replacement for ad-hoc full_case/parallel_case muxes.

Parameters:
N_CH, 4, number of case items/channels (>=2)
DW, 8, data width per channel
MODE, 0, 0 = priority (lowest set index wins, multi-match legal); 1 = unique (lowest index wins, multi-match flagged)
NOMATCH_MODE, 0, 0 = hold last matched output data; 1 = drive DEFAULT_VAL
DEFAULT_VAL, 0, DW-bit value driven on no-match when NOMATCH_MODE=1
CNT_W, 8, violation counter width

Ports:
clk  in  1  single clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept
sel_vec  in  N_CH  match vector, bit i = case item i hit
data_in  in  N_CH*DW  channel i at [i*DW +: DW]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  DW  selected data
out_idx  out  $clog2(N_CH)  selected index (0 on no-match)
out_hit  out  1  at least one item matched
out_multi  out  1  beat violated unique (MODE=1 only, else 0)
out_none  out  1  beat matched no item
clr_cnt  in  1  synchronous counter clear
multi_cnt  out  CNT_W  saturating count of unique violations
none_cnt  out  CNT_W  saturating count of no-match beats

Behaviour:
- Reset (rst_n=0 at a rising edge): out_valid, out_data, out_idx, out_hit, out_multi, out_none, the internal last-data register, multi_cnt and none_cnt all go to 0. in_ready is forced 0 while rst_n=0.
- Handshake: in_ready = ~out_valid | out_ready (single stage, combinational ready path, no skid buffer). Accept = in_valid & in_ready.
- Latency: exactly 1 cycle. An accepted beat appears on the output registers at the next edge with out_valid=1.
- Accept with no new input: out_valid clears when out_ready=1 and in_valid=0.
- Stall: while out_valid & ~out_ready, all out_* hold stable and no input is accepted.
- Selection: idx = lowest i with sel_vec[i]=1; out_data = data_in[idx]. The last-data register updates only on accepted beats with a hit.
- Multi-match (popcount(sel_vec)>1):
  - MODE=0: legal; out_multi=0; no count.
  - MODE=1: out_multi=1 on that beat; multi_cnt increments.
- No-match (sel_vec=0): out_hit=0, out_none=1, out_idx=0, none_cnt increments.
  - out_data = last-data register if NOMATCH_MODE=0, else DEFAULT_VAL.
  - Before any hit since reset, the last-data register is 0.
- Counters:
  - Increment once per accepted beat, never per stalled cycle.
  - Saturate at all-ones with no wrap.
  - clr_cnt=1 forces 0 and wins over a simultaneous increment.
- Sideband flags: out_multi/out_none are beat-qualified; consumers sample them only with out_valid.
- X on sel_vec is not propagated. The design treats it as an illegal stimulus, and the bench asserts no X on sel_vec during in_valid.
- Reset mid-stall: the pending output beat is discarded and counters clear; in_ready is 1 on the first cycle after rst_n returns high.

Test Plan:
1. rst_n=0 for 3 cycles with in_valid=1, sel_vec=4'b0001 -> in_ready=0, out_valid=0, out_data=0, both counters 0. First cycle after release: in_ready=1.
2. MODE=0, sel_vec=4'b0110, data ch1=8'h11, ch2=8'h22, out_ready=1 -> next cycle out_valid=1, out_data=8'h11, out_idx=1, out_multi=0, multi_cnt=0.
3. MODE=1, same stimulus -> out_data=8'h11, out_idx=1, out_multi=1, multi_cnt=1. Then sel_vec=4'b1000, ch3=8'h33 -> out_data=8'h33, out_multi=0, multi_cnt stays 1.
4. NOMATCH_MODE=0: accept sel_vec=4'b0001 with ch0=8'hA5, then sel_vec=0 -> out_data=8'hA5, out_hit=0, out_none=1, none_cnt=1. Repeat with NOMATCH_MODE=1, DEFAULT_VAL=8'h3C -> out_data=8'h3C.
5. Accept sel_vec=0, then out_ready=0 for 4 cycles with in_valid held high -> in_ready=0 throughout, out_* stable, none_cnt=1 (not 4). Releasing out_ready accepts the next beat in the same cycle.
6. CNT_W=2: 5 consecutive no-match beats -> none_cnt=3 (saturated). Then clr_cnt=1 in the same cycle as an accepted no-match beat -> none_cnt=0.

Source files
------------

// File: rtl/case_sel_mux.sv
// Priority/unique case-select mux with a single registered valid/ready output stage.
// Flags no-match and unique-violation beats and keeps saturating counters of both.
module case_sel_mux #(
   parameter int            N_CH         = 4,
   parameter int            DW           = 8,
   parameter int            MODE         = 0,
   parameter int            NOMATCH_MODE = 0,
   parameter logic [DW-1:0] DEFAULT_VAL  = '0,
   parameter int            CNT_W        = 8,
   localparam int           IW           = $clog2(N_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_CH-1:0]      sel_vec,
   input  logic [N_CH*DW-1:0]   data_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic [IW-1:0]        out_idx,
   output logic                 out_hit,
   output logic                 out_multi,
   output logic                 out_none,
   input  logic                 clr_cnt,
   output logic [CNT_W-1:0]     multi_cnt,
   output logic [CNT_W-1:0]     none_cnt
);

   logic             out_valid_q;
   logic [DW-1:0]    out_data_q, out_data_d;
   logic [IW-1:0]    out_idx_q, out_idx_d;
   logic             out_hit_q, out_multi_q, out_none_q;
   logic [DW-1:0]    last_q;
   logic [CNT_W-1:0] multi_cnt_q, multi_cnt_d;
   logic [CNT_W-1:0] none_cnt_q, none_cnt_d;

   logic             accept;
   logic             hit, multi;
   logic [DW-1:0]    sel_data;

   assign in_ready = rst_n & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   // Descending scan so the lowest set index is the last assignment and wins.
   always_comb begin
      out_idx_d = '0;
      sel_data  = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (sel_vec[i]) begin
            out_idx_d = IW'(i);
            sel_data  = data_in[i*DW +: DW];
         end
      end
      hit   = |sel_vec;
      multi = (sel_vec & (sel_vec - N_CH'(1))) != '0;
   end

   always_comb begin
      out_data_d = sel_data;
      if (!hit) begin
         out_data_d = (NOMATCH_MODE != 0) ? DEFAULT_VAL : last_q;
      end
   end

   always_comb begin
      multi_cnt_d = multi_cnt_q;
      none_cnt_d  = none_cnt_q;
      if (clr_cnt) begin
         multi_cnt_d = '0;
         none_cnt_d  = '0;
      end else if (accept) begin
         if ((MODE != 0) && multi && (multi_cnt_q != '1)) begin
            multi_cnt_d = multi_cnt_q + CNT_W'(1);
         end
         if (!hit && (none_cnt_q != '1)) begin
            none_cnt_d = none_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_hit_q   <= 1'b0;
         out_multi_q <= 1'b0;
         out_none_q  <= 1'b0;
         last_q      <= '0;
         multi_cnt_q <= '0;
         none_cnt_q  <= '0;
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_hit_q   <= hit;
            out_multi_q <= (MODE != 0) && multi;
            out_none_q  <= ~hit;
            if (hit) begin
               last_q <= sel_data;
            end
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         multi_cnt_q <= multi_cnt_d;
         none_cnt_q  <= none_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_hit   = out_hit_q;
   assign out_multi = out_multi_q;
   assign out_none  = out_none_q;
   assign multi_cnt = multi_cnt_q;
   assign none_cnt  = none_cnt_q;

endmodule

// File: tb/tb_case_sel_mux.sv
// Directed bench driving two differently configured instances from shared stimulus:
// A = priority / hold-last / 8-bit counters, B = unique / default 8'h3C / 2-bit counters.
module tb_case_sel_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  sel_vec;
   logic [31:0] data_in;
   logic        out_ready;
   logic        clr_cnt;

   logic       a_in_ready, a_out_valid, a_out_hit, a_out_multi, a_out_none;
   logic [7:0] a_out_data, a_multi_cnt, a_none_cnt;
   logic [1:0] a_out_idx;
   logic       b_in_ready, b_out_valid, b_out_hit, b_out_multi, b_out_none;
   logic [7:0] b_out_data;
   logic [1:0] b_out_idx, b_multi_cnt, b_none_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   case_sel_mux #(.N_CH(4), .DW(8), .MODE(0), .NOMATCH_MODE(0), .DEFAULT_VAL(8'h00), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .sel_vec(sel_vec), .data_in(data_in), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_idx(a_out_idx), .out_hit(a_out_hit), .out_multi(a_out_multi),
      .out_none(a_out_none), .clr_cnt(clr_cnt), .multi_cnt(a_multi_cnt), .none_cnt(a_none_cnt));

   case_sel_mux #(.N_CH(4), .DW(8), .MODE(1), .NOMATCH_MODE(1), .DEFAULT_VAL(8'h3C), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
      .sel_vec(sel_vec), .data_in(data_in), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_data(b_out_data), .out_idx(b_out_idx), .out_hit(b_out_hit), .out_multi(b_out_multi),
      .out_none(b_out_none), .clr_cnt(clr_cnt), .multi_cnt(b_multi_cnt), .none_cnt(b_none_cnt));

   // Illegal stimulus guard: sel_vec must be fully known whenever a beat is offered.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && in_valid === 1'b1) begin
         assert (!$isunknown(sel_vec)) else begin
            n_fail++;
            $error("FAIL sel_vec_x: observed %b required no X", sel_vec);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      sel_vec   = 4'b0001;
      data_in   = {8'h33, 8'h22, 8'h11, 8'hA5};
      out_ready = 1'b1;
      clr_cnt   = 1'b0;

      // Reset held with a valid beat offered: nothing accepted, everything zero.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_a_in_ready", a_in_ready, 0);
         check("rst_b_in_ready", b_in_ready, 0);
         check("rst_a_out_valid", a_out_valid, 0);
         check("rst_a_out_data", a_out_data, 0);
         check("rst_a_none_cnt", a_none_cnt, 0);
         check("rst_b_multi_cnt", b_multi_cnt, 0);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rel_a_in_ready", a_in_ready, 1);
      check("rel_b_in_ready", b_in_ready, 1);

      // Multi-match: priority legal in A, unique violation in B.
      in_valid = 1'b1;
      sel_vec  = 4'b0110;
      tick();
      check("mm_a_valid", a_out_valid, 1);
      check("mm_a_data", a_out_data, 8'h11);
      check("mm_a_idx", a_out_idx, 1);
      check("mm_a_multi", a_out_multi, 0);
      check("mm_a_multi_cnt", a_multi_cnt, 0);
      check("mm_b_data", b_out_data, 8'h11);
      check("mm_b_idx", b_out_idx, 1);
      check("mm_b_multi", b_out_multi, 1);
      check("mm_b_multi_cnt", b_multi_cnt, 1);

      sel_vec = 4'b1000;
      tick();
      check("one_a_data", a_out_data, 8'h33);
      check("one_a_idx", a_out_idx, 3);
      check("one_b_data", b_out_data, 8'h33);
      check("one_b_multi", b_out_multi, 0);
      check("one_b_multi_cnt", b_multi_cnt, 1);

      // No-match after a hit on ch0: A holds last data, B drives default.
      sel_vec = 4'b0001;
      tick();
      check("h0_a_data", a_out_data, 8'hA5);
      check("h0_a_idx", a_out_idx, 0);
      sel_vec = 4'b0000;
      tick();
      check("nm_a_data", a_out_data, 8'hA5);
      check("nm_a_hit", a_out_hit, 0);
      check("nm_a_none", a_out_none, 1);
      check("nm_a_idx", a_out_idx, 0);
      check("nm_a_none_cnt", a_none_cnt, 1);
      check("nm_b_data", b_out_data, 8'h3C);
      check("nm_b_none", b_out_none, 1);
      check("nm_b_none_cnt", b_none_cnt, 1);

      // Stall for 4 cycles with a new beat offered.
      out_ready = 1'b0;
      sel_vec   = 4'b0010;
      #1;
      check("st_a_in_ready", a_in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("st_a_in_ready", a_in_ready, 0);
         check("st_a_valid", a_out_valid, 1);
         check("st_a_data", a_out_data, 8'hA5);
         check("st_a_none", a_out_none, 1);
         check("st_a_none_cnt", a_none_cnt, 1);
         check("st_b_none_cnt", b_none_cnt, 1);
      end
      out_ready = 1'b1;
      #1;
      check("unst_a_in_ready", a_in_ready, 1);
      tick();
      check("unst_a_data", a_out_data, 8'h11);
      check("unst_a_idx", a_out_idx, 1);
      check("unst_a_hit", a_out_hit, 1);
      check("unst_a_none_cnt", a_none_cnt, 1);

      // Back-to-back no-match beats: B's 2-bit counter saturates at 3.
      sel_vec = 4'b0000;
      tick();
      tick();
      check("sat2_b_none_cnt", b_none_cnt, 3);
      tick();
      tick();
      tick();
      check("sat5_a_none_cnt", a_none_cnt, 6);
      check("sat5_b_none_cnt", b_none_cnt, 3);

      // Clear wins over a simultaneous increment.
      clr_cnt = 1'b1;
      tick();
      check("clr_a_none_cnt", a_none_cnt, 0);
      check("clr_b_none_cnt", b_none_cnt, 0);
      check("clr_b_multi_cnt", b_multi_cnt, 0);
      check("clr_a_none", a_out_none, 1);
      clr_cnt = 1'b0;

      // Drain with no new input.
      in_valid = 1'b0;
      tick();
      check("drain_a_valid", a_out_valid, 0);
      check("drain_b_valid", b_out_valid, 0);

      // Reset during a stall discards the beat and clears history.
      in_valid = 1'b1;
      tick();
      check("pre_a_none_cnt", a_none_cnt, 1);
      check("pre_a_data", a_out_data, 8'h11);
      out_ready = 1'b0;
      tick();
      check("pre_a_valid", a_out_valid, 1);
      rst_n = 1'b0;
      tick();
      check("mrst_a_valid", a_out_valid, 0);
      check("mrst_a_none_cnt", a_none_cnt, 0);
      check("mrst_a_in_ready", a_in_ready, 0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("mrel_a_in_ready", a_in_ready, 1);
      tick();
      check("post_a_valid", a_out_valid, 1);
      check("post_a_data", a_out_data, 8'h00);
      check("post_b_data", b_out_data, 8'h3C);
      check("post_a_none_cnt", a_none_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
